// File: rtl/carry_skip_add_sequencer.sv
// carry_skip_add_sequencer: multi-cycle W-bit adder (W = N*WORDS) that reuses
// one N-bit carry_skip_adder slice, LSB slice first, with the inter-slice
// carry held in a register. Valid/ready handshake on both sides.
// Optional feature macro: CSA_SEQ_OVF_EN adds the signed-overflow output ovf.

// N-bit carry-skip adder: ripple within each BLOCK_SIZE block, block carry
// bypasses the block when every bit of it propagates.
module carry_skip_adder #(
  parameter int unsigned N          = 8,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic         c;
  logic         blk_cin;
  logic         blk_prop;
  logic [N-1:0] p;

  // Ripple per bit; at each block end, skip the block carry if fully propagating
  always_comb begin
    sum      = '0;
    c        = cin;
    blk_cin  = cin;
    blk_prop = 1'b1;
    p        = a ^ b;
    for (int unsigned i = 0; i < N; i++) begin
      if ((i % BLOCK_SIZE) == 0) begin
        blk_cin  = c;
        blk_prop = 1'b1;
      end
      sum[i]   = p[i] ^ c;
      c        = (a[i] & b[i]) | (p[i] & c);
      blk_prop = blk_prop & p[i];
      if (((i % BLOCK_SIZE) == (BLOCK_SIZE - 1)) || (i == (N - 1))) begin
        if (blk_prop) begin
          c = blk_cin;
        end
      end
    end
    cout = c;
  end

endmodule

module carry_skip_add_sequencer #(
  parameter int unsigned N          = 8,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned WORDS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
`ifdef CSA_SEQ_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam int unsigned W     = N * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef CSA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  logic [N-1:0]     slice_sum;
  logic             slice_cout;
  logic             last_slice;

  carry_skip_adder #(
    .N          (N),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_slice (
    .a    (a_q[N-1:0]),
    .b    (b_q[N-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  // Next-state and datapath: accept in IDLE, one slice per RUN cycle, hold in DONE
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
`ifdef CSA_SEQ_OVF_EN
    ovf_d       = ovf_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
`ifdef CSA_SEQ_OVF_EN
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Slice result enters at the top so that after WORDS shifts slice 0 sits at the LSBs
        sum_d            = sum_q >> N;
        sum_d[W-1 -: N]  = slice_sum;
        a_d              = a_q >> N;
        b_d              = b_q >> N;
        carry_d          = slice_cout;
        idx_d            = idx_q + 1'b1;
        if (last_slice) begin
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
`ifdef CSA_SEQ_OVF_EN
          ovf_d       = (a_msb_q == b_msb_q) && (slice_sum[N-1] != a_msb_q);
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
`ifdef CSA_SEQ_OVF_EN
      ovf_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
`ifdef CSA_SEQ_OVF_EN
      ovf_q       <= ovf_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CSA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_add_sequencer.sv
// Bench for carry_skip_add_sequencer: a WORDS=4 (W=32) instance and a WORDS=1
// (W=8) instance; sel1 chooses which one the shared stimulus drives.
module tb_carry_skip_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic        sel1 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready4, out_valid4, busy4, cout4, ovf4;
  logic [31:0] sum4;
  logic        in_ready1, out_valid1, busy1, cout1, ovf1;
  logic [7:0]  sum1;

  logic        ir, ov, bs, co, of;
  logic [31:0] sm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  carry_skip_add_sequencer #(.N(8), .BLOCK_SIZE(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel1),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sum       (sum4),
    .cout      (cout4),
`ifdef CSA_SEQ_OVF_EN
    .ovf       (ovf4),
`endif
    .busy      (busy4)
  );

  carry_skip_add_sequencer #(.N(8), .BLOCK_SIZE(4), .WORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel1),
    .in_ready  (in_ready1),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .cin       (cin),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .sum       (sum1),
    .cout      (cout1),
`ifdef CSA_SEQ_OVF_EN
    .ovf       (ovf1),
`endif
    .busy      (busy1)
  );

`ifndef CSA_SEQ_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  assign ir = sel1 ? in_ready1  : in_ready4;
  assign ov = sel1 ? out_valid1 : out_valid4;
  assign bs = sel1 ? busy1      : busy4;
  assign co = sel1 ? cout1      : cout4;
  assign of = sel1 ? ovf1       : ovf4;
  assign sm = sel1 ? {24'h0, sum1} : sum4;

  // Present operands for one cycle and count edges until out_valid (-1 on timeout)
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        output int lat);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    lat = 0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready4); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid4); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy4); end
    total++; if ({cout4, sum4} !== 33'h0) begin bad++; $display("FAIL rst_sum got=%h want=0", {cout4, sum4}); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf4); end
    total++; if ({in_ready1, out_valid1, busy1} !== 3'b100) begin bad++; $display("FAIL rst_w1_flags got=%b want=100", {in_ready1, out_valid1, busy1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_wrap();
    int lat;
    a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({ir, bs, ov} !== 3'b010) begin bad++; $display("FAIL t1_after_accept got=%b want=010", {ir, bs, ov}); end
    lat = 1;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
    lat--;
    total++; if (lat !== 4) begin bad++; $display("FAIL t1_latency got=%0d want=4", lat); end
    total++; if (sm !== 32'h0) begin bad++; $display("FAIL t1_sum got=%h want=00000000", sm); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL t1_cout got=%b want=1", co); end
    consume();
    total++; if ({ir, ov, bs} !== 3'b100) begin bad++; $display("FAIL t1_release got=%b want=100", {ir, ov, bs}); end
  endtask

  task automatic test_directed_sums();
    int lat;
    run_op(32'h000000FF, 32'h0, 1'b1, lat);
    total++; if ({co, sm} !== {1'b0, 32'h00000100}) begin bad++; $display("FAIL t2a_sum got=%h want=000000100", {co, sm}); end
    consume();
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, lat);
    total++; if ({co, sm} !== {1'b0, 32'hACF13568}) begin bad++; $display("FAIL t2b_sum got=%h want=0ACF13568", {co, sm}); end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, lat);
    // Next operation is already presented while the result is stalled
    a = 32'h00001234; b = 32'h00004321; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if ({ov, ir, co, sm} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin bad++; $display("FAIL t3_hold[%0d] got ov=%b ir=%b co=%b sum=%h want ov=1 ir=0 co=1 sum=0", i, ov, ir, co, sm); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({ov, ir} !== 2'b01) begin bad++; $display("FAIL t3_release got=%b want=01", {ov, ir}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({ir, bs} !== 2'b01) begin bad++; $display("FAIL t3_held_accept got=%b want=01", {ir, bs}); end
    lat = 0;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if ({co, sm} !== {1'b0, 32'h00005556}) begin bad++; $display("FAIL t3_next_sum got=%h want=000005556", {co, sm}); end
    consume();
  endtask

  task automatic test_abort();
    int lat;
    a = 32'hDEADBEEF; b = 32'h87654321; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ir, ov, bs, co} !== 4'b1000) begin bad++; $display("FAIL t4_flags got=%b want=1000", {ir, ov, bs, co}); end
    total++; if (sm !== 32'h0) begin bad++; $display("FAIL t4_sum got=%h want=0", sm); end
    total++; if (of !== 1'b0) begin bad++; $display("FAIL t4_ovf got=%b want=0", of); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h1, 32'h1, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL t4_latency got=%0d want=4", lat); end
    total++; if ({co, sm} !== 33'h2) begin bad++; $display("FAIL t4_sum_after got=%h want=2", {co, sm}); end
    consume();
  endtask

`ifdef CSA_SEQ_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, lat);
    total++; if (of !== 1'b1) begin bad++; $display("FAIL t5a_ovf got=%b want=1", of); end
    consume();
    run_op(32'h80000000, 32'h80000000, 1'b0, lat);
    total++; if ({of, co, sm} !== {2'b11, 32'h0}) begin bad++; $display("FAIL t5b got ovf=%b cout=%b sum=%h want 1 1 0", of, co, sm); end
    consume();
    run_op(32'h5, 32'h3, 1'b0, lat);
    total++; if ({of, sm} !== {1'b0, 32'h8}) begin bad++; $display("FAIL t5c got ovf=%b sum=%h want 0 8", of, sm); end
    consume();
  endtask
`endif

  // Random operations against {cout,sum} = a+b+cin computed at the selected width
  task automatic test_random(input logic one_word, input int n);
    int          lat, wbits, words, gap, stall;
    logic [31:0] ra, rb, mask, esum;
    logic        rc, ecout, eovf;
    logic [32:0] full;
    sel1  = one_word;
    wbits = one_word ? 8 : 32;
    words = one_word ? 1 : 4;
    mask  = one_word ? 32'h000000FF : 32'hFFFFFFFF;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      ra = $urandom & mask; rb = $urandom & mask; rc = 1'($urandom);
      if (i < 4) begin ra = mask; rb = (i < 2) ? 32'h0 : mask; rc = 1'(i); end
      full  = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      esum  = full[31:0] & mask;
      ecout = full[wbits];
      eovf  = (ra[wbits-1] == rb[wbits-1]) && (esum[wbits-1] != ra[wbits-1]);
      total++; if (ir !== 1'b1) begin bad++; $display("FAIL rnd%0d_idle[%0d] got=%b want=1", words, i, ir); end
      run_op(ra, rb, rc, lat);
      total++; if (lat !== words) begin bad++; $display("FAIL rnd%0d_latency[%0d] got=%0d want=%0d", words, i, lat, words); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++; if ({ov, co, sm} !== {1'b1, ecout, esum}) begin bad++; $display("FAIL rnd%0d_result[%0d] a=%h b=%h cin=%b got ov=%b cout=%b sum=%h want ov=1 cout=%b sum=%h", words, i, ra, rb, rc, ov, co, sm, ecout, esum); end
`ifdef CSA_SEQ_OVF_EN
      total++; if (of !== eovf) begin bad++; $display("FAIL rnd%0d_ovf[%0d] got=%b want=%b", words, i, of, eovf); end
`endif
      consume();
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL rnd%0d_drop[%0d] got=%b want=0", words, i, ov); end
    end
    sel1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_directed_sums();
    test_hold();
    test_abort();
`ifdef CSA_SEQ_OVF_EN
    test_ovf();
`endif
    test_random(1'b0, 2000);
    test_random(1'b1, 2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
